// File: rtl/trace_pkg.sv
// Shared types for the 6507 bus trace buffer.
//   state_t       : capture FSM states.
//   trace_entry_t : one captured CPU cycle at the default widths,
//                   {rw, addr, data} with data in the LSBs.
package trace_pkg;

  localparam int TRACE_ADDR_W = 13;
  localparam int TRACE_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    READ = 2'd3
  } state_t;

  typedef struct packed {
    logic                    rw;
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x ENTRY_W flop array.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : entry written at the clock edge
//   raddr : read index
//   rdata : combinational read of mem[raddr]
// Storage is deliberately unreset; stale words are never exposed because
// the fill level gates what the reader can see.
module trace_ram #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 22,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_bus_trace.sv
// On-chip trace buffer for the 6507 CPU bus.
// Records {rw, addr, data} per completed CPU cycle into a circular buffer,
// freezes post_count samples after an address-match trigger, then drains the
// window oldest-first over a valid/ready stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cap_valid/addr/data/rw : captured CPU cycle (valid low while stalled)
//   arm                 : pulse, clear buffer and start capture
//   oneshot             : 1 = idle after drain, 0 = re-arm after drain
//   trig_addr, trig_en  : packed comparator addresses (comp 0 in LSBs), enables
//   post_count          : samples stored after the trigger sample
//   rd_valid/ready/data/last : drain stream
//   armed, triggered, fill_level : status
module cpu_bus_trace
  import trace_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int NUM_TRIG = 2,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int ENTRY_W = ADDR_W + DATA_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cap_valid,
  input  logic [ADDR_W-1:0]          cap_addr,
  input  logic [DATA_W-1:0]          cap_data,
  input  logic                       cap_rw,
  input  logic                       arm,
  input  logic                       oneshot,
  input  logic [NUM_TRIG*ADDR_W-1:0] trig_addr,
  input  logic [NUM_TRIG-1:0]        trig_en,
  input  logic [PTR_W-1:0]           post_count,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [ENTRY_W-1:0]         rd_data,
  output logic                       rd_last,
  output logic                       armed,
  output logic                       triggered,
  output logic [PTR_W:0]             fill_level
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, post_rem;
  logic [PTR_W:0]     rd_rem;
  logic [PTR_W-1:0]   wr_ptr_inc, rd_start;
  logic [PTR_W:0]     fill_inc;
  logic [ENTRY_W-1:0] ram_rdata;
  logic               hit, wr_en, clear, enter_read, load_post, rd_fire;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      if (trig_en[i] && (cap_addr == trig_addr[i*ADDR_W +: ADDR_W])) hit = 1'b1;
    end
  end

  // Pointer/fill values as they will be once the current sample is written;
  // the read start is taken from these so the final sample is included.
  assign wr_ptr_inc = wr_ptr + PTR_W'(1);
  assign fill_inc   = (fill_level == FULL) ? fill_level : fill_level + 1'b1;
  assign rd_start   = wr_ptr_inc - fill_inc[PTR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // arm overrides everything else in the cycle: no write, no handshake.
  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    clear      = 1'b0;
    enter_read = 1'b0;
    load_post  = 1'b0;
    rd_fire    = 1'b0;
    if (arm) begin
      state_d = PRE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        PRE: begin
          if (cap_valid) begin
            wr_en = 1'b1;
            if (hit) begin
              if (post_count == '0) begin
                state_d    = READ;
                enter_read = 1'b1;
              end else begin
                state_d   = POST;
                load_post = 1'b1;
              end
            end
          end
        end
        POST: begin
          if (cap_valid) begin
            wr_en = 1'b1;
            if (post_rem == PTR_W'(1)) begin
              state_d    = READ;
              enter_read = 1'b1;
            end
          end
        end
        READ: begin
          if (rd_ready) begin
            rd_fire = 1'b1;
            if (rd_rem == (PTR_W+1)'(1)) begin
              if (oneshot) begin
                state_d = IDLE;
              end else begin
                state_d = PRE;
                clear   = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      fill_level <= '0;
      post_rem   <= '0;
      rd_ptr     <= '0;
      rd_rem     <= '0;
    end else begin
      if (clear) begin
        wr_ptr     <= '0;
        fill_level <= '0;
      end else if (wr_en) begin
        wr_ptr     <= wr_ptr_inc;
        fill_level <= fill_inc;
      end
      if (load_post)                     post_rem <= post_count;
      else if (wr_en && state_q == POST) post_rem <= post_rem - PTR_W'(1);
      if (enter_read) begin
        rd_ptr <= rd_start;
        rd_rem <= fill_inc;
      end else if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        rd_rem <= rd_rem - (PTR_W+1)'(1);
      end
    end
  end

  trace_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({cap_rw, cap_addr, cap_data}),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign rd_valid  = (state_q == READ);
  assign rd_data   = rd_valid ? ram_rdata : '0;
  assign rd_last   = rd_valid && (rd_rem == (PTR_W+1)'(1));
  assign armed     = (state_q == PRE) || (state_q == POST);
  assign triggered = (state_q == POST) || (state_q == READ);

endmodule

// File: tb/tb_cpu_bus_trace.sv
// Bench for cpu_bus_trace at DEPTH = 8: a small buffer model queues the
// expected window as samples are driven; the drain pops and compares.
module tb_cpu_bus_trace;
  import trace_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_valid = 1'b0;
  logic [12:0] cap_addr = '0;
  logic [7:0]  cap_data = '0;
  logic        cap_rw = 1'b0;
  logic        arm = 1'b0;
  logic        oneshot = 1'b1;
  logic [25:0] trig_addr = '0;
  logic [1:0]  trig_en = '0;
  logic [2:0]  post_count = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [21:0] rd_data;
  logic        rd_last;
  logic        armed;
  logic        triggered;
  logic [3:0]  fill_level;

  int vectors = 0;
  int miscompares = 0;

  trace_entry_t exp_q[$];
  state_t       ms = IDLE;
  int           mrem = 0;
  bit           rw_alt = 1'b0;

  cpu_bus_trace #(
    .ADDR_W(13), .DATA_W(8), .DEPTH(DEPTH), .NUM_TRIG(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_addr(cap_addr),
    .cap_data(cap_data), .cap_rw(cap_rw), .arm(arm), .oneshot(oneshot),
    .trig_addr(trig_addr), .trig_en(trig_en), .post_count(post_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .armed(armed), .triggered(triggered),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic with_sample, input logic [12:0] a);
    arm = 1'b1;
    cap_valid = with_sample;
    cap_addr = a;
    cap_data = a[7:0];
    exp_q.delete();
    ms = PRE;
    tick();
    arm = 1'b0;
    cap_valid = 1'b0;
  endtask

  // Drive one bus cycle and advance the reference model.
  task automatic cap(input logic [12:0] a, input logic v);
    trace_entry_t e;
    logic hit;
    cap_valid = v;
    cap_addr = a;
    cap_data = a[7:0];
    cap_rw = rw_alt ? ~a[0] : 1'b1;
    hit = (trig_en[0] && a == trig_addr[12:0]) || (trig_en[1] && a == trig_addr[25:13]);
    if (v && (ms == PRE || ms == POST)) begin
      e.rw = cap_rw;
      e.addr = a;
      e.data = a[7:0];
      exp_q.push_back(e);
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      if (ms == PRE) begin
        if (hit) begin
          if (post_count == 0) ms = READ;
          else begin
            ms = POST;
            mrem = int'(post_count);
          end
        end
      end else begin
        mrem--;
        if (mrem == 0) ms = READ;
      end
    end
    tick();
    cap_valid = 1'b0;
  endtask

  task automatic stream(input logic [12:0] start);
    for (int i = 0; i < 40 && ms != READ; i++) cap(start + 13'(i), 1'b1);
    if (ms != READ) chk("stream_no_trigger", 0, 1);
  endtask

  // pat 0: ready always high; pat 1: ready 1-0-0-1 repeating.
  task automatic drain(input logic [12:0] first_a, input logic [12:0] last_a, input int pat);
    int n = 0;
    int guard = 0;
    bit holding = 0;
    bit got_first = 0;
    logic [21:0] held = '0;
    logic [12:0] seen_first = '0, seen_last = '0;
    while (exp_q.size() > 0 && guard < 100) begin
      guard++;
      rd_ready = (pat == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
      n++;
      chk("rd_valid", rd_valid, 1);
      if (holding) chk("rd_hold", rd_data, held);
      if (rd_ready) begin
        chk("rd_data", rd_data, exp_q[0]);
        chk("rd_last", rd_last, exp_q.size() == 1);
        if (!got_first) seen_first = rd_data[20:8];
        got_first = 1;
        seen_last = rd_data[20:8];
        void'(exp_q.pop_front());
        holding = 0;
      end else begin
        held = rd_data;
        holding = 1;
      end
      tick();
    end
    rd_ready = 1'b0;
    if (guard >= 100) chk("drain_timeout", 0, 1);
    chk("first_addr", seen_first, first_a);
    chk("last_addr", seen_last, last_a);
    ms = oneshot ? IDLE : PRE;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_armed", armed, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();

    // basic window
    oneshot = 1'b1;
    trig_en = 2'b01;
    trig_addr = {13'h1FFF, 13'h105};
    post_count = 3'd2;
    do_arm(1'b0, '0);
    chk("arm_armed", armed, 1);
    chk("arm_fill", fill_level, 0);
    chk("arm_trig", triggered, 0);
    stream(13'h100);
    chk("basic_fill", fill_level, 8);
    chk("basic_trig", triggered, 1);
    chk("basic_armed", armed, 0);
    drain(13'h100, 13'h107, 0);
    chk("idle_valid", rd_valid, 0);
    chk("idle_armed", armed, 0);

    // wraparound
    trig_addr = {13'h1FFF, 13'h10A};
    rw_alt = 1'b1;
    do_arm(1'b0, '0);
    stream(13'h100);
    chk("wrap_fill", fill_level, 8);
    drain(13'h105, 13'h10C, 0);

    // minimal window
    trig_addr = {13'h1FFF, 13'h100};
    post_count = 3'd0;
    do_arm(1'b0, '0);
    cap(13'h100, 1'b1);
    chk("min_valid", rd_valid, 1);
    chk("min_fill", fill_level, 1);
    drain(13'h100, 13'h100, 0);

    // stall + second comparator
    trig_en = 2'b10;
    trig_addr = {13'h103, 13'h101};
    post_count = 3'd1;
    do_arm(1'b0, '0);
    cap(13'h100, 1'b1);
    cap(13'h101, 1'b1);
    cap(13'h102, 1'b1);
    cap(13'h103, 1'b0);
    chk("stall_no_trig", triggered, 0);
    chk("stall_fill", fill_level, 3);
    cap(13'h103, 1'b1);
    chk("stall_trig", triggered, 1);
    cap(13'h104, 1'b1);
    chk("stall_fill5", fill_level, 5);
    drain(13'h100, 13'h104, 0);

    // backpressure + auto re-arm
    oneshot = 1'b0;
    trig_en = 2'b01;
    trig_addr = {13'h1FFF, 13'h103};
    post_count = 3'd2;
    do_arm(1'b0, '0);
    stream(13'h100);
    drain(13'h100, 13'h105, 1);
    chk("rearm_armed", armed, 1);
    chk("rearm_fill", fill_level, 0);
    chk("rearm_valid", rd_valid, 0);
    chk("rearm_trig", triggered, 0);

    // arm during POST with a concurrent sample
    oneshot = 1'b1;
    trig_addr = {13'h1FFF, 13'h102};
    post_count = 3'd4;
    do_arm(1'b0, '0);
    cap(13'h100, 1'b1);
    cap(13'h101, 1'b1);
    cap(13'h102, 1'b1);
    cap(13'h103, 1'b1);
    chk("post_trig", triggered, 1);
    do_arm(1'b1, 13'h104);
    chk("restart_fill", fill_level, 0);
    chk("restart_armed", armed, 1);
    chk("restart_trig", triggered, 0);
    trig_addr = {13'h1FFF, 13'h106};
    post_count = 3'd0;
    cap(13'h105, 1'b1);
    cap(13'h106, 1'b1);
    chk("restart_fill2", fill_level, 2);
    drain(13'h105, 13'h106, 0);

    // asynchronous reset mid-READ
    trig_addr = {13'h1FFF, 13'h100};
    post_count = 3'd3;
    do_arm(1'b0, '0);
    stream(13'h100);
    chk("pre_rst_valid", rd_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_armed", armed, 0);
    chk("arst_trig", triggered, 0);
    chk("arst_fill", fill_level, 0);
    #3;
    rst_n = 1'b1;
    exp_q.delete();
    ms = IDLE;
    tick();
    chk("post_rst_valid", rd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
